pam_frame_sched: RTL and testbench
==================================

Name: pam_frame_sched

Overview:
- Frame scheduler between pam_map and the DAC-side output.
- Sequences each transmit frame as: preamble, then pilot, then payload, then guard.
- Preamble and pilot are locally generated. Payload words are drawn from pam_map's PamMap2AddHead_* stream. Guard words are zeros.
- Owns the pam_map output handshake: pam_map advances only during the payload phase.

Parameters:
- AD_CVER_WIDTH, 12, bits per DAC sample; each word carries two samples.
- PREAMBLE_LEN, 32, preamble words per frame (>=1).
- PILOT_LEN, 16, pilot words per frame (>=1).
- PAYLOAD_LEN, 256, payload words per frame (>=1).
- GUARD_LEN, 4, zero words per frame (>=1).
- CNT_WIDTH, 16, phase counter width; must hold the largest of the four lengths.

Ports:
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- cfg_enable, in, 1, allow new frames to start.
- PamMap2AddHead_data, in, 2*AD_CVER_WIDTH, payload word from pam_map.
- PamMap2AddHead_valid, in, 1, payload word valid.
- PamMap2AddHead_ready, out, 1, scheduler accepts a payload word.
- Frame_out_data, out, 2*AD_CVER_WIDTH, output word; upper half is sample 0.
- Frame_out_valid, out, 1, output word valid.
- Frame_out_ready, in, 1, downstream accepts the word.
- Frame_out_sof, out, 1, first preamble word of a frame.
- Frame_out_eof, out, 1, last guard word of a frame.
- frame_busy, out, 1, state is not IDLE.
- frame_cnt, out, 16, completed frames; wraps at 0xFFFF to 0.

Behaviour:
- Level constants: HI=12'h7FF, LO=12'h801.
- Output stage is a single registered slot (data/valid/sof/eof).
- A new word loads when the slot is empty or Frame_out_ready=1 (load_en = !Frame_out_valid || Frame_out_ready).
- Holding rule: a valid word holds data, sof and eof stable until accepted.
- Reset: all outputs are 0 and the state is IDLE.
- States: IDLE, PREAMBLE, PILOT, PAYLOAD, GUARD.
- Phase counter: cleared on every state entry. It increments on each word loaded into the output slot.
- IDLE -> PREAMBLE requires cfg_enable=1 AND PamMap2AddHead_valid=1 when sampled, so no frame starts without payload pending.
- PREAMBLE:
  - Word k (k from 0) is {HI,LO} for even k and {LO,HI} for odd k.
  - sof=1 on k=0.
  - Moves to PILOT after PREAMBLE_LEN loads.
- PILOT:
  - 8-bit LFSR, reseeded to 8'hA5 on PILOT entry.
  - Output bit is lfsr[7]. Feedback is lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]. Next state is {lfsr[6:0],fb}.
  - Bit 1 produces word {HI,HI}; bit 0 produces {LO,LO}.
  - LFSR steps once per loaded word.
  - Moves to PAYLOAD after PILOT_LEN loads.
- PAYLOAD:
  - PamMap2AddHead_ready = load_en, only in this state; it is 0 in every other state.
  - The slot loads PamMap2AddHead_data on valid&&ready.
  - Latency from pam_map handshake to Frame_out_valid is 1 cycle.
  - If pam_map is not valid (underrun), the slot empties and Frame_out_valid drops. The frame stalls with no filler inserted.
  - Moves to GUARD after PAYLOAD_LEN accepted words.
- GUARD:
  - Words are all zeros.
  - eof=1 on the last word.
  - After GUARD_LEN loads, frame_cnt increments by 1. Next state is PREAMBLE if the IDLE start condition holds that cycle, otherwise IDLE. Frames may therefore run back-to-back.
- cfg_enable deasserting mid-frame: the current frame completes, then the block returns to IDLE.
- rst mid-frame: everything is cleared on the next edge. The partial frame is abandoned with no eof, and frame_cnt is not incremented.
- Frame_out_ready low: all counters and the LFSR freeze. No word is dropped or duplicated.
- Total output words per frame: PREAMBLE_LEN+PILOT_LEN+PAYLOAD_LEN+GUARD_LEN.

Test Plan:
Bench parameters for all scenarios: PREAMBLE_LEN=4, PILOT_LEN=4, PAYLOAD_LEN=8, GUARD_LEN=2.
- Nominal frame:
  - Stimulus: cfg_enable=1, pam_map always valid with data 24'h000001..24'h000008, Frame_out_ready=1.
  - Required: 18 consecutive words with sof on word 0 and eof on word 17. Preamble is 7FF801, 8017FF, 7FF801, 8017FF. Pilot is 7FF7FF, 801801, 7FF7FF, 801801. Then payload 000001..000008, then 000000 twice. frame_cnt=1.
- Start gating:
  - Stimulus: cfg_enable=1 with pam_map valid=0 for 20 cycles.
  - Required: Frame_out_valid=0, frame_busy=0, PamMap2AddHead_ready=0 throughout.
- Backpressure:
  - Stimulus: Frame_out_ready toggling as 4 cycles low / 4 cycles high, as in the pam_map bench pattern.
  - Required: the word sequence is identical to the nominal frame, with no drops or repeats, and data stays stable while valid&&!ready.
- Payload underrun:
  - Stimulus: pam_map valid drops for 5 cycles after payload word 3.
  - Required: Frame_out_valid=0 during the gap, then words 4..8 follow. No extra words appear.
- Back-to-back and disable:
  - Stimulus: cfg_enable held for 2 frames, then cleared mid-preamble of frame 3.
  - Required: 3 complete frames with no idle gap between frames 1 and 2. frame_cnt=3, then IDLE.
- Reset mid-payload:
  - Stimulus: rst=1 for 1 cycle at payload word 5.
  - Required: all outputs are 0 next cycle, and frame_cnt stays at its previous value. The next frame restarts with a sof preamble.

Source files
------------

// File: rtl/pam_frame_sched.sv
// pam_frame_sched: builds each transmit frame as preamble, pilot, payload
// (taken from pam_map) and guard, through a single registered output slot.
// The pam_map handshake is only opened during the payload phase.
module pam_frame_sched #(
  parameter int AD_CVER_WIDTH = 12,
  parameter int PREAMBLE_LEN  = 32,
  parameter int PILOT_LEN     = 16,
  parameter int PAYLOAD_LEN   = 256,
  parameter int GUARD_LEN     = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_enable,
  input  logic [2*AD_CVER_WIDTH-1:0]   PamMap2AddHead_data,
  input  logic                         PamMap2AddHead_valid,
  output logic                         PamMap2AddHead_ready,
  output logic [2*AD_CVER_WIDTH-1:0]   Frame_out_data,
  output logic                         Frame_out_valid,
  input  logic                         Frame_out_ready,
  output logic                         Frame_out_sof,
  output logic                         Frame_out_eof,
  output logic                         frame_busy,
  output logic [15:0]                  frame_cnt
);

  localparam int DW = 2 * AD_CVER_WIDTH;

  // Full-scale positive level and its two's-complement negative.
  localparam logic [AD_CVER_WIDTH-1:0] HI = {1'b0, {(AD_CVER_WIDTH-1){1'b1}}};
  localparam logic [AD_CVER_WIDTH-1:0] LO = {1'b1, {(AD_CVER_WIDTH-2){1'b0}}, 1'b1};

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  localparam logic [CNT_WIDTH-1:0] PRE_LAST = CNT_WIDTH'(PREAMBLE_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] PIL_LAST = CNT_WIDTH'(PILOT_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] PAY_LAST = CNT_WIDTH'(PAYLOAD_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] GRD_LAST = CNT_WIDTH'(GUARD_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_PILOT,
    S_PAYLOAD,
    S_GUARD
  } state_t;

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [7:0]             r_lfsr;
  logic [DW-1:0]          r_data;
  logic                   r_valid;
  logic                   r_sof;
  logic                   r_eof;
  logic [15:0]            r_frame_cnt;

  state_t                 w_state_next;
  logic [CNT_WIDTH-1:0]   w_cnt_next;
  logic [7:0]             w_lfsr_next;
  logic [DW-1:0]          w_data_next;
  logic                   w_valid_next;
  logic                   w_sof_next;
  logic                   w_eof_next;
  logic [15:0]            w_frame_cnt_next;
  logic                   w_src_ready;

  // The slot may take a new word when it is empty or is being drained.
  logic w_load_en;
  logic w_start;
  logic w_lfsr_fb;

  assign w_load_en = !r_valid || Frame_out_ready;
  assign w_start   = cfg_enable && PamMap2AddHead_valid;
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // Next-state, counter, LFSR and output-slot logic; nothing moves unless the slot can load.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_lfsr_next      = r_lfsr;
    w_data_next      = r_data;
    w_valid_next     = r_valid;
    w_sof_next       = r_sof;
    w_eof_next       = r_eof;
    w_frame_cnt_next = r_frame_cnt;
    w_src_ready      = 1'b0;

    // A drained slot with nothing new to load becomes empty.
    if (w_load_en) begin
      w_valid_next = 1'b0;
      w_sof_next   = 1'b0;
      w_eof_next   = 1'b0;
      w_data_next  = '0;
    end

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = S_PREAMBLE;
          w_cnt_next   = '0;
        end
      end

      S_PREAMBLE: begin
        if (w_load_en) begin
          w_valid_next = 1'b1;
          w_data_next  = r_cnt[0] ? {LO, HI} : {HI, LO};
          w_sof_next   = (r_cnt == '0);
          if (r_cnt == PRE_LAST) begin
            w_state_next = S_PILOT;
            w_cnt_next   = '0;
            w_lfsr_next  = LFSR_SEED;
          end else begin
            w_cnt_next = r_cnt + CNT_WIDTH'(1);
          end
        end
      end

      S_PILOT: begin
        if (w_load_en) begin
          w_valid_next = 1'b1;
          w_data_next  = r_lfsr[7] ? {HI, HI} : {LO, LO};
          w_lfsr_next  = {r_lfsr[6:0], w_lfsr_fb};
          if (r_cnt == PIL_LAST) begin
            w_state_next = S_PAYLOAD;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_WIDTH'(1);
          end
        end
      end

      S_PAYLOAD: begin
        w_src_ready = w_load_en;
        // On underrun the slot simply empties; no filler is inserted.
        if (w_load_en && PamMap2AddHead_valid) begin
          w_valid_next = 1'b1;
          w_data_next  = PamMap2AddHead_data;
          if (r_cnt == PAY_LAST) begin
            w_state_next = S_GUARD;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_WIDTH'(1);
          end
        end
      end

      S_GUARD: begin
        if (w_load_en) begin
          w_valid_next = 1'b1;
          w_data_next  = '0;
          w_eof_next   = (r_cnt == GRD_LAST);
          if (r_cnt == GRD_LAST) begin
            w_frame_cnt_next = r_frame_cnt + 16'd1;
            w_state_next     = w_start ? S_PREAMBLE : S_IDLE;
            w_cnt_next       = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_WIDTH'(1);
          end
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State, counters, LFSR and output slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_lfsr      <= LFSR_SEED;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_lfsr      <= w_lfsr_next;
      r_data      <= w_data_next;
      r_valid     <= w_valid_next;
      r_sof       <= w_sof_next;
      r_eof       <= w_eof_next;
      r_frame_cnt <= w_frame_cnt_next;
    end
  end

  assign PamMap2AddHead_ready = w_src_ready;
  assign Frame_out_data       = r_data;
  assign Frame_out_valid      = r_valid;
  assign Frame_out_sof        = r_sof;
  assign Frame_out_eof        = r_eof;
  assign frame_busy           = (r_state != S_IDLE);
  assign frame_cnt            = r_frame_cnt;

endmodule

// File: tb/tb_pam_frame_sched.sv
// tb_pam_frame_sched: scoreboard bench for pam_frame_sched with short frame
// lengths (4 preamble, 4 pilot, 8 payload, 2 guard words).
module tb_pam_frame_sched;

  localparam int AW = 12;
  localparam int DW = 2 * AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_enable = 1'b0;
  logic [DW-1:0] PamMap2AddHead_data = '0;
  logic          PamMap2AddHead_valid = 1'b0;
  logic          PamMap2AddHead_ready;
  logic [DW-1:0] Frame_out_data;
  logic          Frame_out_valid;
  logic          Frame_out_ready = 1'b1;
  logic          Frame_out_sof;
  logic          Frame_out_eof;
  logic          frame_busy;
  logic [15:0]   frame_cnt;

  pam_frame_sched #(
    .AD_CVER_WIDTH(AW),
    .PREAMBLE_LEN (4),
    .PILOT_LEN    (4),
    .PAYLOAD_LEN  (8),
    .GUARD_LEN    (2),
    .CNT_WIDTH    (16)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cfg_enable          (cfg_enable),
    .PamMap2AddHead_data (PamMap2AddHead_data),
    .PamMap2AddHead_valid(PamMap2AddHead_valid),
    .PamMap2AddHead_ready(PamMap2AddHead_ready),
    .Frame_out_data      (Frame_out_data),
    .Frame_out_valid     (Frame_out_valid),
    .Frame_out_ready     (Frame_out_ready),
    .Frame_out_sof       (Frame_out_sof),
    .Frame_out_eof       (Frame_out_eof),
    .frame_busy          (frame_busy),
    .frame_cnt           (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard entries are {sof, eof, data}.
  logic [DW+1:0] exp_q[$];
  logic [DW-1:0] src_q[$];

  logic [DW+1:0] mon_exp;
  logic [DW+1:0] held;
  logic          hold_pend = 1'b0;
  logic          mon_en = 1'b0;
  int            out_count = 0;

  int  cyc_n    = 0;
  int  gap      = 0;
  int  gap_at   = 0;
  int  src_pops = 0;
  bit  bp_mode  = 1'b0;
  bit  was_gap  = 1'b0;
  int  exp_fcnt = 0;

  // Output monitor: compares every accepted word with the scoreboard and
  // checks that a stalled word stays put.
  always @(negedge clk) begin
    if (!mon_en) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        n_cmp++;
        if (!Frame_out_valid || {Frame_out_sof, Frame_out_eof, Frame_out_data} !== held) begin
          n_fail++;
          $display("FAIL hold_stable: got v=%0b sof/eof/data=%h required v=1 %h",
                   Frame_out_valid, {Frame_out_sof, Frame_out_eof, Frame_out_data}, held);
        end
      end
      hold_pend = Frame_out_valid && !Frame_out_ready;
      held      = {Frame_out_sof, Frame_out_eof, Frame_out_data};
      if (Frame_out_valid && Frame_out_ready) begin
        out_count++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_word: got %h required no word", held);
        end else begin
          mon_exp = exp_q.pop_front();
          if (held !== mon_exp) begin
            n_fail++;
            $display("FAIL word_%0d: got sof/eof/data=%h required %h", out_count - 1, held, mon_exp);
          end
        end
      end
    end
  end

  task automatic drive_src();
    PamMap2AddHead_valid = (src_q.size() > 0) && (gap == 0);
    PamMap2AddHead_data  = (src_q.size() > 0) ? src_q[0] : '0;
  endtask

  // One clock: sample the pam_map handshake, then update stimulus after the edge.
  task automatic cycle();
    logic fire;
    @(negedge clk);
    fire = PamMap2AddHead_valid && PamMap2AddHead_ready;
    @(posedge clk);
    #1;
    cyc_n++;
    was_gap = (gap > 0);
    if (gap > 0) gap--;
    if (fire && src_q.size() > 0) begin
      void'(src_q.pop_front());
      src_pops++;
      if (src_pops == gap_at) gap = 5;
    end
    Frame_out_ready = bp_mode ? (((cyc_n / 4) % 2) == 1) : 1'b1;
    drive_src();
  endtask

  // Expected frame and the matching pam_map payload words.
  task automatic push_frame(input logic [DW-1:0] base);
    logic [DW-1:0] pil [4];
    pil[0] = 24'h7FF7FF; pil[1] = 24'h801801; pil[2] = 24'h7FF7FF; pil[3] = 24'h801801;
    for (int k = 0; k < 4; k++)
      exp_q.push_back({(k == 0), 1'b0, ((k % 2) == 0) ? 24'h7FF801 : 24'h8017FF});
    for (int k = 0; k < 4; k++)
      exp_q.push_back({2'b00, pil[k]});
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back({2'b00, base + DW'(k)});
      src_q.push_back(base + DW'(k));
    end
    exp_q.push_back({2'b00, 24'h000000});
    exp_q.push_back({2'b01, 24'h000000});
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || frame_busy || Frame_out_valid) && n < budget) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || frame_busy || Frame_out_valid) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d words outstanding after %0d cycles, required 0", name, exp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(); cycle(); cycle();
    n_cmp++;
    if ({Frame_out_valid, Frame_out_sof, Frame_out_eof, frame_busy, PamMap2AddHead_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got v/sof/eof/busy/rdy=%b required 00000",
               {Frame_out_valid, Frame_out_sof, Frame_out_eof, frame_busy, PamMap2AddHead_ready});
    end
    n_cmp++;
    if (Frame_out_data !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 000000", Frame_out_data);
    end
    n_cmp++;
    if (frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    cycle();
  endtask

  task automatic test_reset_mid_payload();
    int n = 0;
    cfg_enable = 1'b1;
    src_pops = 0;
    push_frame(24'h000000);
    drive_src();
    while (src_pops < 5 && n < 100) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (src_pops < 5) begin
      n_fail++;
      $display("FAIL rstmid_reach_payload: got %0d payload words required 5", src_pops);
    end
    mon_en = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    src_q.delete();
    drive_src();
    cycle();
    n_cmp++;
    if ({Frame_out_valid, Frame_out_sof, Frame_out_eof, frame_busy, PamMap2AddHead_ready} !== 5'b0 ||
        Frame_out_data !== 24'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got v/sof/eof/busy/rdy=%b data=%h required all 0",
               {Frame_out_valid, Frame_out_sof, Frame_out_eof, frame_busy, PamMap2AddHead_ready}, Frame_out_data);
    end
    n_cmp++;
    if (frame_cnt !== 16'(exp_fcnt)) begin
      n_fail++;
      $display("FAIL rstmid_frame_cnt: got %0d required %0d", frame_cnt, exp_fcnt);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    push_frame(24'h000000);
    drive_src();
    wait_done(200, "rstmid_restart");
    exp_fcnt++;
    n_cmp++;
    if (frame_cnt !== 16'(exp_fcnt)) begin
      n_fail++;
      $display("FAIL rstmid_restart_cnt: got %0d required %0d", frame_cnt, exp_fcnt);
    end
  endtask

  task automatic test_nominal();
    out_count = 0;
    push_frame(24'h000000);
    drive_src();
    wait_done(200, "nominal");
    exp_fcnt++;
    n_cmp++;
    if (out_count != 18) begin
      n_fail++;
      $display("FAIL nominal_word_count: got %0d required 18", out_count);
    end
    n_cmp++;
    if (frame_cnt !== 16'(exp_fcnt)) begin
      n_fail++;
      $display("FAIL nominal_frame_cnt: got %0d required %0d", frame_cnt, exp_fcnt);
    end
  endtask

  task automatic test_start_gating();
    cfg_enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_cmp++;
      if ({Frame_out_valid, frame_busy, PamMap2AddHead_ready} !== 3'b000) begin
        n_fail++;
        $display("FAIL gating_cycle_%0d: got v/busy/rdy=%b required 000", i,
                 {Frame_out_valid, frame_busy, PamMap2AddHead_ready});
      end
    end
  endtask

  task automatic test_backpressure();
    out_count = 0;
    bp_mode = 1'b1;
    push_frame(24'h000000);
    drive_src();
    wait_done(400, "backpressure");
    bp_mode = 1'b0;
    Frame_out_ready = 1'b1;
    exp_fcnt++;
    n_cmp++;
    if (out_count != 18) begin
      n_fail++;
      $display("FAIL bp_word_count: got %0d required 18", out_count);
    end
    n_cmp++;
    if (frame_cnt !== 16'(exp_fcnt)) begin
      n_fail++;
      $display("FAIL bp_frame_cnt: got %0d required %0d", frame_cnt, exp_fcnt);
    end
  endtask

  task automatic test_underrun();
    int n = 0;
    int gaps = 0;
    out_count = 0;
    src_pops = 0;
    gap_at = 3;
    push_frame(24'h000100);
    drive_src();
    while ((exp_q.size() != 0 || frame_busy || Frame_out_valid) && n < 300) begin
      cycle();
      n++;
      if (was_gap) begin
        gaps++;
        n_cmp++;
        if (Frame_out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL underrun_gap_%0d: got valid=%0b data=%h required valid=0", gaps, Frame_out_valid, Frame_out_data);
        end
      end
    end
    gap_at = 0;
    exp_fcnt++;
    n_cmp++;
    if (exp_q.size() != 0 || gaps != 5 || out_count != 18) begin
      n_fail++;
      $display("FAIL underrun_totals: got outstanding=%0d gaps=%0d words=%0d required 0/5/18", exp_q.size(), gaps, out_count);
    end
    n_cmp++;
    if (frame_cnt !== 16'(exp_fcnt)) begin
      n_fail++;
      $display("FAIL underrun_frame_cnt: got %0d required %0d", frame_cnt, exp_fcnt);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    out_count = 0;
    cfg_enable = 1'b1;
    push_frame(24'h000010);
    push_frame(24'h000020);
    push_frame(24'h000030);
    src_q.push_back(24'hABCDEF);
    drive_src();
    while ((exp_q.size() != 0 || frame_busy || Frame_out_valid) && n < 400) begin
      cycle();
      n++;
      if (out_count >= 38) cfg_enable = 1'b0;
      if (out_count >= 1 && out_count < 36) begin
        n_cmp++;
        if (Frame_out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_no_gap_word_%0d: got valid=%0b required 1", out_count, Frame_out_valid);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || out_count != 54) begin
      n_fail++;
      $display("FAIL b2b_totals: got outstanding=%0d words=%0d required 0/54", exp_q.size(), out_count);
    end
    exp_fcnt += 3;
    n_cmp++;
    if (frame_cnt !== 16'(exp_fcnt)) begin
      n_fail++;
      $display("FAIL b2b_frame_cnt: got %0d required %0d", frame_cnt, exp_fcnt);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_cmp++;
      if ({frame_busy, Frame_out_valid, PamMap2AddHead_ready} !== 3'b000) begin
        n_fail++;
        $display("FAIL b2b_idle_cycle_%0d: got busy/v/rdy=%b required 000", i,
                 {frame_busy, Frame_out_valid, PamMap2AddHead_ready});
      end
    end
    src_q.delete();
    drive_src();
  endtask

  initial begin
    test_reset();
    test_reset_mid_payload();
    test_nominal();
    test_start_gating();
    test_backpressure();
    test_underrun();
    test_back_to_back();
    cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
